out_ser_gearbox: RTL and testbench
==================================

// Module: out_ser_gearbox
// PURPOSE
//  Transmit-side I/O gearbox: counterpart of the input capture register path.
//  - Accepts parallel words on a valid/ready handshake.
//  - Shifts each word out serially through a registered pad output Q, with a registered tristate control TQ.
//  - Sits between core logic and the output pad buffer; one bit per SCLK cycle.
//  - Back-to-back words stream with no gap cycles.
// PARAMETERS
//  WIDTH          8    bits per word (>=2)
//  LSB_FIRST      1    1: bit 0 shifted out first; 0: bit WIDTH-1 first
//  IDLE_LEVEL     1    value held on Q while no word is being sent
//  TRISTATE_IDLE  0    1: TQ=1 (pad released) while idle; 0: pad always driven
// PORTS
//  SCLK     in   1      single clock, all state on rising edge
//  RSTN     in   1      asynchronous active-low reset
//  TXD      in   WIDTH  parallel word to send
//  TXVALID  in   1      TXD valid
//  TXREADY  out  1      block can accept TXD this cycle
//  Q        out  1      registered serial data to pad
//  TQ       out  1      registered tristate control, 1 = pad released
//  FRAME    out  1      registered, high during the bit period of bit 0 of each word (alignment marker)
//  BUSY     out  1      high while a word is shifting
// BEHAVIOUR
//  Reset (RSTN=0, asynchronous):
//   Q=IDLE_LEVEL, TQ=TRISTATE_IDLE, FRAME=0, BUSY=0, state=IDLE, bit counter=0, shift register=0.
//   Deassertion is taken synchronously into the next SCLK edge.
//  Handshake: transfer when TXVALID && TXREADY at a rising edge.
//   - TXREADY = (state==IDLE) || (state==SHIFT && cnt==WIDTH-1); combinational from state only, never from TXVALID.
//  States:
//   - IDLE: Q=IDLE_LEVEL, TQ=TRISTATE_IDLE. On transfer:
//     - load TXD into the shift register;
//     - first bit appears on Q the next cycle (latency 1 edge);
//     - TQ=0 and FRAME=1 together with it; cnt=0; -> SHIFT.
//   - SHIFT: each edge presents the next bit on Q and cnt++. At cnt==WIDTH-1 (last bit on Q):
//     - if transfer: reload, cnt=0, FRAME=1 next cycle, stay SHIFT (zero-gap stream);
//     - else: next edge Q=IDLE_LEVEL, TQ=TRISTATE_IDLE, BUSY=0 -> IDLE.
//  Bit order: LSB_FIRST=1 shifts right emitting sr[0]; else shifts left emitting sr[WIDTH-1].
//  Counter: $clog2(WIDTH) bits; wraps only via reload, never free-runs past WIDTH-1.
//  BUSY is registered, equals (state==SHIFT).
//  Outputs Q/TQ/FRAME come straight from flops (IOB-packable), no logic after the register.
//  Boundaries:
//   - TXVALID held while busy mid-word: not accepted until the last bit; TXD must stay stable.
//   - TXVALID dropping before acceptance is legal; nothing is sent.
//   - Reset mid-word: word discarded, outputs return to reset values immediately; no partial word resumes.
//   - WIDTH non-power-of-2: counter compare is exact (WIDTH-1), no modulo-2^n wrap.
// STRUCTURE
//  Shared package (io_gearbox_pkg):
//   - state enum {ST_IDLE, ST_SHIFT};
//   - CNT_W function (clog2 with min 1), reused by the input deserializer.
//  Sub-module out_reg_cd: one bit output flop with async active-low clear to parameter INIT.
//   - Instantiated for Q (INIT=IDLE_LEVEL), TQ (INIT=TRISTATE_IDLE), FRAME (INIT=0).
//  Control FSM, counter and shift register stay in this module.
// TESTING
//  1 Reset: RSTN=0 with TXVALID=1, TXD=8'hA5 -> Q=1, TQ=0, BUSY=0, TXREADY=1, no transfer; release -> idle persists.
//  2 Single word, WIDTH=8, LSB_FIRST=1, TXD=8'hA5 -> Q bits 1,0,1,0,0,1,0,1 on 8 cycles starting 1 edge after accept:
//    - FRAME=1 only on the first bit;
//    - Q=1 and BUSY=0 afterwards;
//    - TXREADY=1 on the last bit cycle.
//  3 Back-to-back 8'h0F then 8'hF0 with TXVALID held -> 16 contiguous bits 1111000000001111, FRAME pulses 8 cycles apart, no idle bit.
//  4 LSB_FIRST=0, TXD=8'h80 -> first Q bit 1 then seven 0s; TRISTATE_IDLE=1 -> TQ=1 idle, 0 exactly for the 8 bit cycles.
//  5 Reset pulse at bit 3 of 8'hFF -> Q=IDLE_LEVEL and BUSY=0 within the same cycle (async); next accepted word starts cleanly at bit 0.
//  6 TXVALID asserted on cycle 2 of a word with TXD=8'h3C -> TXREADY=0 until bit 7; accepted then, 8'h3C emitted with no gap.

Source files
------------

// File: rtl/io_gearbox_pkg.sv
// Shared types and helpers for the I/O gearbox pair (serializer and deserializer).
package io_gearbox_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // Bit-counter width for a word of 'width' bits; never narrower than one bit.
   function automatic int CNT_W(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/out_ser_gearbox_if.sv
// Parallel word handshake between core logic and the transmit gearbox.
interface out_ser_gearbox_if #(
   parameter int WIDTH = 8
) ();
   logic [WIDTH-1:0] txd;
   logic             txvalid;
   logic             txready;

   modport master (output txd, output txvalid, input txready);
   modport slave  (input txd, input txvalid, output txready);
endinterface

// File: rtl/out_reg_cd.sv
// Single output flop with asynchronous active-low clear to INIT; one per pad-facing output.
module out_reg_cd #(
   parameter bit INIT = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_q;

   // Plain D flop, cleared to INIT; nothing sits between r_q and the pad
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_q <= INIT;
      else          r_q <= i_d;
   end

   assign o_q = r_q;

endmodule

// File: rtl/out_ser_gearbox.sv
// Transmit gearbox: takes parallel words on valid/ready and emits them one bit per
// clock on a registered pad output, with registered tristate and frame marker.
module out_ser_gearbox
   import io_gearbox_pkg::*;
#(
   parameter int WIDTH         = 8,
   parameter bit LSB_FIRST     = 1'b1,
   parameter bit IDLE_LEVEL    = 1'b1,
   parameter bit TRISTATE_IDLE = 1'b0
) (
   input  logic                i_sclk,
   input  logic                i_rstn,
   out_ser_gearbox_if.slave    tx,
   output logic                o_q,
   output logic                o_tq,
   output logic                o_frame,
   output logic                o_busy
);

   localparam int             CW   = CNT_W(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_sr;
   logic             r_busy;

   logic             w_last;
   logic             w_ready;
   logic             w_xfer;
   logic             w_ld_bit;
   logic [WIDTH-1:0] w_ld_sr;
   logic             w_nx_bit;
   logic [WIDTH-1:0] w_nx_sr;
   logic             w_q_d;
   logic             w_tq_d;
   logic             w_frame_d;

   // Ready depends on state only, so a source may hold valid without a comb loop
   assign w_last     = (r_state == ST_SHIFT) && (r_cnt == LAST);
   assign w_ready    = (r_state == ST_IDLE) || w_last;
   assign w_xfer     = tx.txvalid && w_ready;
   assign tx.txready = w_ready;

   // First bit goes straight to the pad flop on load; the rest is kept in r_sr
   always_comb begin
      if (LSB_FIRST) begin
         w_ld_bit = tx.txd[0];
         w_ld_sr  = tx.txd >> 1;
         w_nx_bit = r_sr[0];
         w_nx_sr  = r_sr >> 1;
      end else begin
         w_ld_bit = tx.txd[WIDTH-1];
         w_ld_sr  = tx.txd << 1;
         w_nx_bit = r_sr[WIDTH-1];
         w_nx_sr  = r_sr << 1;
      end
   end

   // Next values for the pad flops: load, shift, or fall back to idle levels
   always_comb begin
      w_q_d     = IDLE_LEVEL;
      w_tq_d    = TRISTATE_IDLE;
      w_frame_d = 1'b0;
      if (w_xfer) begin
         w_q_d     = w_ld_bit;
         w_tq_d    = 1'b0;
         w_frame_d = 1'b1;
      end else if ((r_state == ST_SHIFT) && !w_last) begin
         w_q_d  = w_nx_bit;
         w_tq_d = 1'b0;
      end
   end

   // Control FSM: counter tracks which bit is on the pad; reload at the last bit streams gap-free
   always_ff @(posedge i_sclk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_sr    <= '0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_xfer) begin
                  r_sr    <= w_ld_sr;
                  r_cnt   <= '0;
                  r_state <= ST_SHIFT;
                  r_busy  <= 1'b1;
               end
            end
            ST_SHIFT: begin
               if (w_last) begin
                  if (w_xfer) begin
                     r_sr  <= w_ld_sr;
                     r_cnt <= '0;
                  end else begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_sr  <= w_nx_sr;
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   out_reg_cd #(.INIT(IDLE_LEVEL)) u_q (
      .i_clk(i_sclk), .i_rst_n(i_rstn), .i_d(w_q_d), .o_q(o_q)
   );

   out_reg_cd #(.INIT(TRISTATE_IDLE)) u_tq (
      .i_clk(i_sclk), .i_rst_n(i_rstn), .i_d(w_tq_d), .o_q(o_tq)
   );

   out_reg_cd #(.INIT(1'b0)) u_frame (
      .i_clk(i_sclk), .i_rst_n(i_rstn), .i_d(w_frame_d), .o_q(o_frame)
   );

   assign o_busy = r_busy;

endmodule

// File: tb/tb_out_ser_gearbox.sv
// Bench for out_ser_gearbox: three configurations against a timestamp-based word model.
module tb_out_ser_gearbox;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Per-instance configuration: 0 = 8b LSB-first driven idle, 1 = 8b MSB-first tristate idle,
   // 2 = 5b LSB-first, idle low, tristate idle
   int   W   [3] = '{8, 8, 5};
   logic LSB [3] = '{1'b1, 1'b0, 1'b1};
   logic IDL [3] = '{1'b1, 1'b1, 1'b0};
   logic TRI [3] = '{1'b0, 1'b1, 1'b1};

   logic       tv [3];
   logic [7:0] td [3];
   logic [2:0] q, tq, fr, bz;
   logic [4:0] ob [3];

   int npass = 0;
   int nchk  = 0;

   out_ser_gearbox_if #(.WIDTH(8)) if0 ();
   out_ser_gearbox_if #(.WIDTH(8)) if1 ();
   out_ser_gearbox_if #(.WIDTH(5)) if2 ();

   assign if0.txvalid = tv[0];
   assign if0.txd     = td[0];
   assign if1.txvalid = tv[1];
   assign if1.txd     = td[1];
   assign if2.txvalid = tv[2];
   assign if2.txd     = td[2][4:0];

   out_ser_gearbox #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1), .TRISTATE_IDLE(1'b0)) dut0 (
      .i_sclk(clk), .i_rstn(rst_n), .tx(if0),
      .o_q(q[0]), .o_tq(tq[0]), .o_frame(fr[0]), .o_busy(bz[0]));
   out_ser_gearbox #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1), .TRISTATE_IDLE(1'b1)) dut1 (
      .i_sclk(clk), .i_rstn(rst_n), .tx(if1),
      .o_q(q[1]), .o_tq(tq[1]), .o_frame(fr[1]), .o_busy(bz[1]));
   out_ser_gearbox #(.WIDTH(5), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0), .TRISTATE_IDLE(1'b1)) dut2 (
      .i_sclk(clk), .i_rstn(rst_n), .tx(if2),
      .o_q(q[2]), .o_tq(tq[2]), .o_frame(fr[2]), .o_busy(bz[2]));

   assign ob[0] = {q[0], tq[0], fr[0], bz[0], if0.txready};
   assign ob[1] = {q[1], tq[1], fr[1], bz[1], if1.txready};
   assign ob[2] = {q[2], tq[2], fr[2], bz[2], if2.txready};

   // Reference model: a word accepted at edge a owns the pad for edges a..a+W-1,
   // showing bit k (in send order) after edge a+k.
   int         cyc = 0;
   logic       act [3] = '{1'b0, 1'b0, 1'b0};
   int         acc [3] = '{0, 0, 0};
   logic [7:0] wrd [3];

   // Expected {Q, TQ, FRAME, BUSY, TXREADY} as seen after the current edge
   function automatic logic [4:0] exp_o(input int d);
      int   k;
      logic b;
      k = cyc - acc[d];
      if (act[d] && k >= 0 && k < W[d]) begin
         b = LSB[d] ? wrd[d][k] : wrd[d][W[d]-1-k];
         return {b, 1'b0, (k == 0), 1'b1, (k == W[d]-1)};
      end
      return {IDL[d], TRI[d], 1'b0, 1'b0, 1'b1};
   endfunction

   function automatic logic m_ready(input int d);
      logic [4:0] e;
      e = exp_o(d);
      return e[0];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int d = 0; d < 3; d++) act[d] <= 1'b0;
      end else begin
         cyc <= cyc + 1;
         for (int d = 0; d < 3; d++)
            if (tv[d] && m_ready(d)) begin
               act[d] <= 1'b1;
               acc[d] <= cyc + 1;
               wrd[d] <= td[d];
            end
      end
   end

   task test_reset;
      logic [4:0] rst_exp [3];
      logic [4:0] e;
      rst_exp = '{5'b10001, 5'b11001, 5'b01001};
      for (int d = 0; d < 3; d++) begin tv[d] = 1'b1; td[d] = 8'hA5; end
      #12;
      for (int d = 0; d < 3; d++) begin
         nchk++;
         if (ob[d] !== rst_exp[d]) $display("FAIL reset_hold dut%0d got %b want %b", d, ob[d], rst_exp[d]);
         else npass++;
      end
      for (int d = 0; d < 3; d++) tv[d] = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            e = exp_o(d); nchk++;
            if (ob[d] !== e || ob[d] !== rst_exp[d]) $display("FAIL reset_release dut%0d got %b want %b", d, ob[d], rst_exp[d]);
            else npass++;
         end
      end
   endtask

   task test_single;
      logic [4:0] e;
      logic [7:0] qs, fs, rs;
      @(negedge clk); tv[0] = 1'b1; td[0] = 8'hA5;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            e = exp_o(d); nchk++;
            if (ob[d] !== e) $display("FAIL single dut%0d cyc %0d got %b want %b", d, cyc, ob[d], e);
            else npass++;
         end
         if (i == 0) tv[0] = 1'b0;
         if (i < 8) begin qs = {qs[6:0], q[0]}; fs = {fs[6:0], fr[0]}; rs = {rs[6:0], if0.txready}; end
         if (i == 8) begin
            nchk++;
            if ({q[0], bz[0]} !== 2'b10) $display("FAIL single_after got q/busy %b want 10", {q[0], bz[0]});
            else npass++;
         end
      end
      nchk++; if (qs !== 8'b10100101) $display("FAIL single_bits got %b want 10100101", qs); else npass++;
      nchk++; if (fs !== 8'b10000000) $display("FAIL single_frame got %b want 10000000", fs); else npass++;
      nchk++; if (rs !== 8'b00000001) $display("FAIL single_ready got %b want 00000001", rs); else npass++;
   endtask

   task test_back_to_back;
      logic [4:0]  e;
      logic [15:0] qs, fs;
      @(negedge clk); tv[0] = 1'b1; td[0] = 8'h0F;
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            e = exp_o(d); nchk++;
            if (ob[d] !== e) $display("FAIL b2b dut%0d cyc %0d got %b want %b", d, cyc, ob[d], e);
            else npass++;
         end
         if (i == 0) td[0] = 8'hF0;
         if (i == 8) tv[0] = 1'b0;
         if (i < 16) begin qs = {qs[14:0], q[0]}; fs = {fs[14:0], fr[0]}; end
      end
      nchk++; if (qs !== 16'b1111000000001111) $display("FAIL b2b_bits got %b want 1111000000001111", qs); else npass++;
      nchk++; if (fs !== 16'b1000000010000000) $display("FAIL b2b_frame got %b want 1000000010000000", fs); else npass++;
   endtask

   task test_msb_tristate;
      logic [4:0] e;
      logic [7:0] qs;
      logic [9:0] ts;
      @(negedge clk);
      nchk++; if (tq[1] !== 1'b1) $display("FAIL msb_tq_idle got %b want 1", tq[1]); else npass++;
      tv[1] = 1'b1; td[1] = 8'h80;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            e = exp_o(d); nchk++;
            if (ob[d] !== e) $display("FAIL msb dut%0d cyc %0d got %b want %b", d, cyc, ob[d], e);
            else npass++;
         end
         if (i == 0) tv[1] = 1'b0;
         if (i < 8) qs = {qs[6:0], q[1]};
         ts = {ts[8:0], tq[1]};
      end
      nchk++; if (qs !== 8'b10000000) $display("FAIL msb_bits got %b want 10000000", qs); else npass++;
      nchk++; if (ts !== 10'b0000000011) $display("FAIL msb_tq got %b want 0000000011", ts); else npass++;
   endtask

   task test_midword_valid;
      logic [4:0] e;
      logic [6:0] rs;
      logic [7:0] qs, fs;
      @(negedge clk); tv[0] = 1'b1; td[0] = 8'h55;
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            e = exp_o(d); nchk++;
            if (ob[d] !== e) $display("FAIL midword dut%0d cyc %0d got %b want %b", d, cyc, ob[d], e);
            else npass++;
         end
         if (i >= 1 && i <= 7) rs = {rs[5:0], if0.txready};
         if (i >= 8 && i <= 15) begin qs = {qs[6:0], q[0]}; fs = {fs[6:0], fr[0]}; end
         if (i == 0) tv[0] = 1'b0;
         if (i == 1) begin tv[0] = 1'b1; td[0] = 8'h3C; end
         if (i == 8) tv[0] = 1'b0;
      end
      nchk++; if (rs !== 7'b0000001) $display("FAIL midword_ready got %b want 0000001", rs); else npass++;
      nchk++; if (qs !== 8'b00111100) $display("FAIL midword_bits got %b want 00111100", qs); else npass++;
      nchk++; if (fs !== 8'b10000000) $display("FAIL midword_frame got %b want 10000000", fs); else npass++;
   endtask

   task test_reset_midword;
      logic [4:0] e;
      logic [7:0] qs, fs;
      @(negedge clk); tv[0] = 1'b1; td[0] = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            e = exp_o(d); nchk++;
            if (ob[d] !== e) $display("FAIL rstmid_pre dut%0d cyc %0d got %b want %b", d, cyc, ob[d], e);
            else npass++;
         end
         if (i == 0) tv[0] = 1'b0;
      end
      #2 rst_n = 1'b0;
      #1;
      nchk++;
      if ({q[0], tq[0], fr[0], bz[0]} !== 4'b1000)
         $display("FAIL rstmid_async got %b want 1000", {q[0], tq[0], fr[0], bz[0]});
      else npass++;
      for (int d = 0; d < 3; d++) begin
         e = exp_o(d); nchk++;
         if (ob[d] !== e) $display("FAIL rstmid_idle dut%0d got %b want %b", d, ob[d], e);
         else npass++;
      end
      @(negedge clk); rst_n = 1'b1; tv[0] = 1'b1; td[0] = 8'h01;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            e = exp_o(d); nchk++;
            if (ob[d] !== e) $display("FAIL rstmid_post dut%0d cyc %0d got %b want %b", d, cyc, ob[d], e);
            else npass++;
         end
         if (i == 0) tv[0] = 1'b0;
         if (i < 8) begin qs = {qs[6:0], q[0]}; fs = {fs[6:0], fr[0]}; end
      end
      nchk++; if (qs !== 8'b10000000) $display("FAIL rstmid_bits got %b want 10000000", qs); else npass++;
      nchk++; if (fs !== 8'b10000000) $display("FAIL rstmid_frame got %b want 10000000", fs); else npass++;
   endtask

   task test_random;
      logic [4:0] e;
      for (int i = 0; i < 420; i++) begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            e = exp_o(d); nchk++;
            if (ob[d] !== e) $display("FAIL random dut%0d cyc %0d got %b want %b", d, cyc, ob[d], e);
            else npass++;
         end
         for (int d = 0; d < 3; d++) begin
            if (i < 400) begin
               tv[d] = ($urandom_range(0, 3) != 0);
               td[d] = 8'($urandom);
            end else begin
               tv[d] = 1'b0;
            end
         end
      end
   endtask

   initial begin
      test_reset;
      test_single;
      test_back_to_back;
      test_msb_tristate;
      test_midword_valid;
      test_reset_midword;
      test_random;
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
